// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates a byte-wide single-port RAM between IF and MEM and serialises 1/2/4-byte accesses.
// Define ARB_FAIR_EN to let a waiting IF win after FAIR_LIMIT consecutive MEM grants.
module ram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int FAIR_LIMIT = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    input  logic              if_clear_in,
    input  logic              mem_req_in,
    input  logic              mem_rw_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [2:0]        mem_len_in,
    input  logic [31:0]       mem_wdata_in,
    input  logic [7:0]        ram_din_in,
    output logic              ram_rw_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [7:0]        ram_dout_out,
    output logic              if_done_out,
    output logic [31:0]       if_inst_out,
    output logic              mem_done_out,
    output logic [31:0]       mem_rdata_out
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d, len_q, len_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       asm_q, asm_d, asm_ins;
    logic [31:0]       if_inst_q, if_inst_d, mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
    logic              if_go, mem_go, idle_ok, fair_win, grant_mem, grant_if;

    assign if_go     = if_req_in && !if_clear_in;
    assign mem_go    = mem_req_in && (mem_len_in == 3'd1 || mem_len_in == 3'd2 || mem_len_in == 3'd4);
    assign idle_ok   = state_q == IDLE && !if_done_q && !mem_done_q;
    assign grant_mem = idle_ok && mem_go && !fair_win;
    assign grant_if  = idle_ok && if_go && !grant_mem;

`ifdef ARB_FAIR_EN
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    logic [FW-1:0] fair_cnt_q, fair_cnt_d;
    assign fair_win = if_go && fair_cnt_q == FW'(FAIR_LIMIT);
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (!if_req_in || grant_if)
            fair_cnt_d = '0;
        else if (grant_mem && !if_clear_in && !fair_win && fair_cnt_q != FW'(FAIR_LIMIT))
            fair_cnt_d = fair_cnt_q + 1'b1;
    end
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) fair_cnt_q <= '0;
        else         fair_cnt_q <= fair_cnt_d;
`else
    logic unused_fair_limit;
    assign unused_fair_limit = FAIR_LIMIT[0];
    assign fair_win = 1'b0;
`endif

    // byte cnt-1 arrives this cycle because the RAM answers one cycle after the address
    always_comb begin
        asm_ins = asm_q;
        for (int i = 0; i < 4; i++)
            if (cnt_q == 3'(i + 1)) asm_ins[8*i +: 8] = ram_din_in;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        owner_d     = owner_q;
        base_d      = base_q;
        asm_d       = asm_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_mem) begin
                    state_d = mem_rw_in ? WRITE : READ;
                    owner_d = 1'b1;
                    base_d  = mem_addr_in;
                    len_d   = mem_len_in;
                    asm_d   = mem_rw_in ? mem_wdata_in : '0;
                end else if (grant_if) begin
                    state_d = READ;
                    owner_d = 1'b0;
                    base_d  = if_addr_in;
                    len_d   = 3'd4;
                    asm_d   = '0;
                end
            end
            READ: begin
                cnt_d = cnt_q + 3'd1;
                asm_d = asm_ins;
                if (!owner_q && if_clear_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == len_q) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    if_done_d   = !owner_q;
                    mem_done_d  = owner_q;
                    if_inst_d   = owner_q ? if_inst_q : asm_ins;
                    mem_rdata_d = owner_q ? asm_ins : mem_rdata_q;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            owner_q     <= 1'b0;
            base_q      <= '0;
            asm_q       <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            asm_q       <= asm_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end

    assign ram_rw_out    = state_q == WRITE;
    assign ram_addr_out  = state_q == IDLE ? '0 : base_q + ADDR_W'(cnt_q);
    assign ram_dout_out  = state_q == WRITE ? asm_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign if_done_out   = if_done_q;
    assign if_inst_out   = if_inst_q;
    assign mem_done_out  = mem_done_q;
    assign mem_rdata_out = mem_rdata_q;
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port RAM arbiter and byte sequencer between instruction fetch (IF) and the memory stage (MEM). It grants the byte-wide RAM port to one requester at a time and serialises 1/2/4-byte accesses into consecutive byte cycles. Read bytes are assembled little-endian and returned with a one-cycle done pulse. It sits between the IF/MEM pipeline stages and the external RAM, replacing direct per-stage RAM access.

## Interface
- ADDR_W, 32, address width
- FAIR_LIMIT, 4, consecutive MEM grants allowed while IF waits (only with ARB_FAIR_EN)
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset; one clock; reset is asynchronous and active-low
- if_req_in  in  1  IF fetch request, held until if_done_out
- if_addr_in  in  ADDR_W  fetch base address
- if_clear_in  in  1  abort pending/in-flight fetch (branch redirect)
- mem_req_in  in  1  MEM request, held until mem_done_out
- mem_rw_in  in  1  0 = read, 1 = write
- mem_addr_in  in  ADDR_W  base address
- mem_len_in  in  3  byte count; legal values 1, 2, 4
- mem_wdata_in  in  32  store data, byte i = bits 8i+7:8i
- ram_din_in  in  8  RAM read data; 1-cycle latency
- ram_rw_out  out  1  0 = read, 1 = write
- ram_addr_out  out  ADDR_W  RAM byte address
- ram_dout_out  out  8  RAM write byte
- if_done_out  out  1  one-cycle pulse; if_inst_out valid
- if_inst_out  out  32  fetched instruction
- mem_done_out  out  1  one-cycle pulse; load data valid / store complete
- mem_rdata_out  out  32  zero-extended load data

## Operation
- States: IDLE, READ, WRITE; 3-bit byte counter cnt; 1-bit owner (IF/MEM); base address, length, and 32-bit assembly register latched at grant.
- Grant in IDLE only when neither done output is high. MEM has priority over IF. With ARB_FAIR_EN, IF wins instead when fair_cnt == FAIR_LIMIT. A grant is never preempted.
- IF grant: length 4, read. MEM grant: length mem_len_in, READ or WRITE per mem_rw_in. cnt <= 0.
- READ: ram_addr_out = base + cnt, ram_rw_out = 0. Each edge does cnt++. When cnt >= 1, ram_din_in is written into byte cnt-1. The edge with cnt == len captures the last byte, pulses done for the owner, and returns to IDLE.
- WRITE: ram_rw_out = 1, ram_addr_out = base + cnt, ram_dout_out = wdata byte cnt. The edge with cnt == len-1 pulses mem_done_out and returns to IDLE.
- ram_rw_out is forced 0 in IDLE and READ. In IDLE, ram_addr_out = 0 and ram_dout_out = 0.
- Address arithmetic wraps modulo 2^ADDR_W.
- Load data is little-endian; bytes at and above len are zero.
- if_clear_in:
  - In IDLE, it suppresses IF grant that cycle.
  - While IF owns READ, the next edge returns to IDLE with no if_done_out. The RAM read is harmless.
  - No effect on MEM transactions.
- A requester sampled in a done cycle is not regranted. Requesters drop req on seeing done.
- Illegal mem_len_in (0, 3, 5–7): no grant to MEM; IF is still serviced.

## Timing
- Reset values: state IDLE, cnt 0, ram_rw_out 0, ram_addr_out 0, ram_dout_out 0, both done 0, if_inst_out 0, mem_rdata_out 0, fair_cnt 0.
- Reset mid-transaction aborts immediately. A partial store may remain in RAM.
- Read of L bytes: req seen in cycle 0, RAM addresses driven in cycles 1..L, done high in cycle L+2. A fetch therefore completes in cycle 6.
- Write of L bytes: bytes driven in cycles 1..L, done high in cycle L+1.
- Data outputs hold their value until the next done of the same port.

## Configuration
- ARB_FAIR_EN defined:
  - fair_cnt increments on each MEM grant while if_req_in is high and not cleared.
  - It resets on IF grant or when if_req_in is low.
  - At FAIR_LIMIT, IF is granted next even if MEM requests.
- ARB_FAIR_EN undefined: strict MEM priority; fair_cnt and FAIR_LIMIT are unused. IF can starve.

## Test plan
- IF fetch at 0x100, RAM bytes 13 05 00 00 -> ram_addr 0x100..0x103 in cycles 1–4, if_done_out in cycle 6, if_inst_out = 0x00000513.
- MEM store len 2 at 0x200, wdata 0xAABBCCDD -> ram_rw 1 with (0x200, DD), (0x201, CC), mem_done_out in cycle 3. Then a len-4 load at 0x200 returns 0x....CCDD per RAM contents; a len-1 load returns 0x000000DD.
- IF and MEM requesting in the same cycle -> MEM granted first, IF granted in the cycle after mem_done_out. No overlap on ram_addr_out.
- if_clear_in asserted in cycle 3 of a fetch -> state IDLE next edge, no if_done_out, a pending MEM request is granted next.
- With ARB_FAIR_EN and FAIR_LIMIT = 2: continuous MEM loads plus IF request -> grant order MEM, MEM, IF, MEM. Without the macro: only MEM is granted.
- rst_in low mid-write (cycle 2) -> all outputs are at their reset values asynchronously. After release, a fresh fetch completes normally.
